systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
Upstream operand stage for systolic_array.
- Buffers one DIM x DIM operand tile, written one vector per handshake.
- On start, streams the tile into the array's A (or B) edge with diagonal skew: lane r is delayed r cycles.
- Drives the array's enable.
- Two instances per array: one feeding the A edge, one feeding the B edge.

Parameters:
BITS_AB, 32, operand width; matches systolic_array.
DIM, 8, tile dimension / number of output lanes; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  load vector valid.
in_ready  output  1  feeder can accept a load vector this cycle.
in_vec  input  [BITS_AB-1:0] x DIM (unpacked [DIM-1:0])  load vector; element k is column k.
start  input  1  begin streaming; honoured only in state FULL.
busy  output  1  high in STREAM.
full  output  1  high in FULL.
out_en  output  1  registered; drives array en.
out_vec  output  [BITS_AB-1:0] x DIM (unpacked [DIM-1:0])  registered skewed lanes.
done  output  1  one-cycle pulse on the cycle after the last stream beat.

Behaviour:
- Reset (async, rst_n low) sets:
  - state = EMPTY, load count = 0, stream count = 0;
  - out_en = 0, out_vec all zero, done = 0, busy = 0, full = 0;
  - tile storage contents don't-care.
- Reset mid-operation aborts immediately. No partial stream resumes.
- States: EMPTY, LOAD, FULL, STREAM.
- EMPTY: in_ready = 1. The first accepted vector goes to LOAD, or to FULL when DIM = 1 (not a supported configuration).
- LOAD: in_ready = 1.
  - Each cycle with in_valid & in_ready stores in_vec as row lcnt: M[lcnt][k] = in_vec[k].
  - lcnt increments on each accepted vector.
  - The accept that makes lcnt reach DIM moves to FULL. lcnt clears to 0.
- FULL: in_ready = 0, full = 1. start moves to STREAM next cycle. in_valid is ignored.
- start outside FULL is ignored. It is not latched.
- STREAM: beat t = 0 .. 2*DIM-2, one beat per cycle, no stalls.
  - Registered output, visible the cycle after the beat is computed.
  - out_vec[r] = M[r][t-r] when 0 <= t-r < DIM; otherwise 0.
  - out_en = 1 for exactly 2*DIM-1 consecutive cycles.
  - The first out_en cycle is the second clock edge after start is sampled in FULL.
- After the final beat is registered, the next cycle has:
  - out_en = 0, out_vec = 0, done = 1;
  - state = EMPTY, so a new load may be accepted in that same cycle.
- in_ready = 0 throughout STREAM.
- Zero padding: out_vec is all zero whenever out_en = 0. Lanes outside their diagonal window are zero while out_en = 1.
- Counters: lcnt is clog2(DIM)+1 bits; scnt is clog2(2*DIM) bits. No wrap occurs within a tile.
- No arithmetic on data. Values pass bit-exact.

Optional Feature:
Macro: SKEW_FEEDER_TRANSPOSE_EN.
- Defined: accepted vector i is stored as column i, M[k][i] = in_vec[k]. Use this for the B-edge instance, so a row-major B tile feeds columns.
- Undefined: row storage as specified above.
- Stream timing, handshakes and zero padding are identical in both builds.

Decomposition:
- Package systolic_pkg:
  - default DIM_DEFAULT = 8 and BITS_AB_DEFAULT = 32;
  - typedef enum logic [1:0] feeder_state_t {EMPTY, LOAD, FULL, STREAM};
  - localparam function stream_beats(DIM) = 2*DIM-1.
- One sub-module, skew_lane: per-lane registered mux.
  - Inputs: beat index, lane index, DIM-wide row.
  - Output: the selected element or zero.
  - Instantiated DIM times in a generate loop.

Test Plan:
1. DIM=4, reset: load rows M[r][k] = 16*r+k, then pulse start.
   - out_en high for 7 cycles.
   - Beat 0 out_vec = {0,0,0,0x00}, i.e. lane0 = 0x00, others 0.
   - Beat 3 lanes = {0x03,0x12,0x21,0x30}.
   - Beat 6 lane3 = 0x33, others 0.
   - done pulses once, then in_ready = 1.
2. Load 3 of 4 vectors, assert start → ignored; busy stays 0. The 4th vector gives full = 1. start then streams normally.
3. In FULL and during STREAM, drive in_valid = 1 with 0xDEAD vectors → in_ready = 0; the streamed data is unchanged from the loaded tile.
4. Assert rst_n low at stream beat 2 → out_en, out_vec, busy and done are 0 asynchronously. After release, state = EMPTY and in_ready = 1.
5. Back-to-back tiles: load the next tile starting in the done cycle → the second stream matches the second tile, with no stale lanes.
6. SKEW_FEEDER_TRANSPOSE_EN defined, same stimulus as test 1 → beat 3 lanes = {0x30,0x21,0x12,0x03}.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic operand feeders.
package systolic_pkg;

  localparam int DIM_DEFAULT     = 8;
  localparam int BITS_AB_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    FULL,
    STREAM
  } feeder_state_t;

  function automatic int stream_beats(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Load-side handshake bundle for systolic_skew_feeder: one tile row/column per accepted beat.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [BITS_AB-1:0] in_vec [DIM-1:0];

  modport master (
    output in_valid,
    output in_vec,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    output in_ready
  );

endinterface

// File: rtl/skew_lane.sv
// One output lane of the skew feeder: registers row[beat-lane] inside the lane's diagonal window, else zero.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT,
  localparam int IW     = $clog2(DIM),
  localparam int SW     = $clog2(2 * DIM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [SW-1:0]      beat,
  input  logic [SW-1:0]      lane,
  input  logic [BITS_AB-1:0] row [DIM-1:0],
  output logic [BITS_AB-1:0] q
);

  logic [SW-1:0] off;
  logic          hit;

  always_comb begin
    off = beat - lane;
    hit = en && (beat >= lane) && (off < SW'(DIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (hit) begin
      q <= row[off[IW-1:0]];
    end else begin
      q <= '0;
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Tile buffer + diagonal-skew streamer for one systolic_array edge.
// Define SKEW_FEEDER_TRANSPOSE_EN to store accepted vectors as columns (B-edge instance).
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_skew_feeder_if.slave ld,
  input  logic                  start,
  output logic                  busy,
  output logic                  full,
  output logic                  out_en,
  output logic [BITS_AB-1:0]    out_vec [DIM-1:0],
  output logic                  done
);

  localparam int IW = $clog2(DIM);
  localparam int LW = IW + 1;
  localparam int SW = $clog2(2 * DIM);

  localparam logic [LW-1:0] LCNT_LAST = LW'(DIM - 1);
  // STREAM spans one cycle beyond the last beat so that beat can be registered.
  localparam logic [SW-1:0] SCNT_LAST = SW'(stream_beats(DIM));

  feeder_state_t state_q, state_d;
  logic [LW-1:0] lcnt_q;
  logic [SW-1:0] scnt_q;
  logic          accept;
  logic          beat_en;
  logic          scnt_end;

  logic [BITS_AB-1:0] mem [DIM-1:0][DIM-1:0];

  always_comb begin
    accept   = ld.in_valid && ld.in_ready;
    scnt_end = (scnt_q == SCNT_LAST);
    beat_en  = (state_q == STREAM) && !scnt_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:  if (accept) state_d = (DIM == 1) ? FULL : LOAD;
      LOAD:   if (accept && (lcnt_q == LCNT_LAST)) state_d = FULL;
      FULL:   if (start) state_d = STREAM;
      STREAM: if (scnt_end) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ld.in_ready = (state_q == EMPTY) || (state_q == LOAD);
    busy        = (state_q == STREAM);
    full        = (state_q == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
    end else if (accept) begin
      lcnt_q <= (lcnt_q == LCNT_LAST) ? '0 : lcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
    end else if (state_q == STREAM) begin
      scnt_q <= scnt_end ? '0 : scnt_q + 1'b1;
    end else begin
      scnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      out_en <= beat_en;
      done   <= (state_q == STREAM) && scnt_end;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < DIM; k++) begin
`ifdef SKEW_FEEDER_TRANSPOSE_EN
        mem[k][lcnt_q[IW-1:0]] <= ld.in_vec[k];
`else
        mem[lcnt_q[IW-1:0]][k] <= ld.in_vec[k];
`endif
      end
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    skew_lane #(
      .BITS_AB(BITS_AB),
      .DIM    (DIM)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (beat_en),
      .beat (scnt_q),
      .lane (SW'(r)),
      .row  (mem[r]),
      .q    (out_vec[r])
    );
  end

endmodule
